// File: rtl/jogo_sequencia_param.sv
// rtl/jogo_sequencia_param.sv - parametrised sequence-memory game core; optional play timeout under JOGO_TIMEOUT_EN
module jogo_sequencia_param #(
    parameter int N_CHAVES       = 4,
    parameter int DEPTH          = 16,
    parameter int NUM_RODADAS    = 16,
    parameter int SHOW_CYCLES    = 50000000,
    parameter int GAP_CYCLES     = 25000000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             iniciar,
    input  logic [N_CHAVES-1:0]              chaves,
    input  logic                             carrega,
    input  logic [$clog2(DEPTH)-1:0]         endereco,
    input  logic [N_CHAVES-1:0]              dado,
    output logic                             acertou,
    output logic                             errou,
    output logic                             pronto,
    output logic [N_CHAVES-1:0]              leds,
    output logic [$clog2(NUM_RODADAS+1)-1:0] rodada,
    output logic                             timeout,
    output logic [3:0]                       db_estado
);

    localparam int AW   = $clog2(DEPTH);
    localparam int RW   = $clog2(NUM_RODADAS + 1);
    localparam int MAXC = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        PREPARA    = 3'd1,
        MOSTRA     = 3'd2,
        ESPERA     = 3'd3,
        COMPARA    = 3'd4,
        PROXIMA    = 3'd5,
        FIM_ACERTO = 3'd6,
        FIM_ERRO   = 3'd7
    } estado_t;

    // Parameter sanity checks, evaluated at elaboration only
    if (N_CHAVES < 2) begin : g_chk_chaves
        $error("N_CHAVES must be at least 2");
    end
    if (NUM_RODADAS < 1 || NUM_RODADAS > DEPTH) begin : g_chk_rodadas
        $error("NUM_RODADAS must be in 1..DEPTH");
    end
    if (SHOW_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_chk_ciclos
        $error("cycle counts must be at least 1");
    end

    logic [N_CHAVES-1:0] mem [DEPTH];

    estado_t             state_q, state_d;
    logic [RW-1:0]       rodada_q, rodada_d;
    logic [AW-1:0]       indice_q, indice_d;
    logic [AW-1:0]       item_q, item_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                fase_q, fase_d;      // 0: item lit, 1: dark gap
    logic [N_CHAVES-1:0] jogada_q, jogada_d;
    logic [N_CHAVES-1:0] chaves_q;
    logic                iniciar_q;
    logic [N_CHAVES-1:0] leds_q, leds_d;
    logic                acertou_q, errou_q, pronto_q;

`ifdef JOGO_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          timeout_q, timeout_d;
`endif

    logic inicio;
    logic nova_jogada;
    logic ultimo_item;
    logic ultimo_indice;
    logic one_hot;
    logic pode_escrever;

    assign inicio        = iniciar && !iniciar_q;
    assign nova_jogada   = (chaves != '0) && (chaves_q == '0);
    assign ultimo_item   = (32'(item_q) + 32'd1 == 32'(rodada_q));
    assign ultimo_indice = (32'(indice_q) + 32'd1 == 32'(rodada_q));
    assign one_hot       = (jogada_q != '0) && ((jogada_q & (jogada_q - N_CHAVES'(1))) == '0);
    assign pode_escrever = (state_q == INICIAL) || (state_q == FIM_ACERTO) || (state_q == FIM_ERRO);

    // Sequence memory: written only while no game is running; reset leaves contents intact
    always_ff @(posedge clock) begin
        if (!reset && carrega && pode_escrever) begin
            mem[endereco] <= dado;
        end
    end

    // Next-state logic, round/playback/play bookkeeping and registered output values
    always_comb begin
        state_d  = state_q;
        rodada_d = rodada_q;
        indice_d = indice_q;
        item_d   = item_q;
        cnt_d    = cnt_q;
        fase_d   = fase_q;
        jogada_d = jogada_q;
`ifdef JOGO_TIMEOUT_EN
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            INICIAL, FIM_ACERTO, FIM_ERRO: begin
                if (inicio) begin
                    state_d  = PREPARA;
                    rodada_d = RW'(1);
`ifdef JOGO_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            PREPARA: begin
                state_d = MOSTRA;
                item_d  = '0;
                cnt_d   = '0;
                fase_d  = 1'b0;
            end
            MOSTRA: begin
                if (!fase_q) begin
                    if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
                        cnt_d  = '0;
                        fase_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_d  = '0;
                        fase_d = 1'b0;
                        if (ultimo_item) begin
                            state_d  = ESPERA;
                            indice_d = '0;
`ifdef JOGO_TIMEOUT_EN
                            wcnt_d = '0;
`endif
                        end else begin
                            item_d = item_q + AW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ESPERA: begin
                if (nova_jogada) begin
                    jogada_d = chaves;
                    state_d  = COMPARA;
                end
`ifdef JOGO_TIMEOUT_EN
                else if (wcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = FIM_ERRO;
                    timeout_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
`endif
            end
            COMPARA: begin
                if (!one_hot || (jogada_q != mem[indice_q])) begin
                    state_d = FIM_ERRO;
                end else if (!ultimo_indice) begin
                    indice_d = indice_q + AW'(1);
                    state_d  = ESPERA;
`ifdef JOGO_TIMEOUT_EN
                    wcnt_d = '0;
`endif
                end else if (rodada_q == RW'(NUM_RODADAS)) begin
                    state_d = FIM_ACERTO;
                end else begin
                    state_d = PROXIMA;
                end
            end
            PROXIMA: begin
                rodada_d = rodada_q + RW'(1);
                state_d  = MOSTRA;
                item_d   = '0;
                cnt_d    = '0;
                fase_d   = 1'b0;
            end
            default: state_d = INICIAL;
        endcase

        leds_d = '0;
        if (state_d == MOSTRA && !fase_d) begin
            leds_d = mem[item_d];
        end else if (state_d == ESPERA) begin
            leds_d = chaves;
        end
    end

    // State and output registers; outputs follow the state being entered so they line up with db_estado
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= INICIAL;
            rodada_q  <= '0;
            indice_q  <= '0;
            item_q    <= '0;
            cnt_q     <= '0;
            fase_q    <= 1'b0;
            jogada_q  <= '0;
            chaves_q  <= '0;
            iniciar_q <= 1'b0;
            leds_q    <= '0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            pronto_q  <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rodada_q  <= rodada_d;
            indice_q  <= indice_d;
            item_q    <= item_d;
            cnt_q     <= cnt_d;
            fase_q    <= fase_d;
            jogada_q  <= jogada_d;
            chaves_q  <= chaves;
            iniciar_q <= iniciar;
            leds_q    <= leds_d;
            acertou_q <= (state_d == FIM_ACERTO);
            errou_q   <= (state_d == FIM_ERRO);
            pronto_q  <= (state_d == FIM_ACERTO) || (state_d == FIM_ERRO);
`ifdef JOGO_TIMEOUT_EN
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign acertou   = acertou_q;
    assign errou     = errou_q;
    assign pronto    = pronto_q;
    assign leds      = leds_q;
    assign rodada    = rodada_q;
    assign db_estado = {1'b0, state_q};
`ifdef JOGO_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// tb/tb_jogo_sequencia_param.sv - directed-vector bench for jogo_sequencia_param
module tb_jogo_sequencia_param;

    localparam int NC   = 4;
    localparam int NR   = 4;
    localparam int SHOW = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 50;
    localparam int CYC  = SHOW + GAP;

    logic          clock;
    logic          reset;
    logic          iniciar;
    logic [NC-1:0] chaves;
    logic          carrega;
    logic [3:0]    endereco;
    logic [NC-1:0] dado;
    logic          acertou;
    logic          errou;
    logic          pronto;
    logic [NC-1:0] leds;
    logic [2:0]    rodada;
    logic          timeout;
    logic [3:0]    db_estado;

    int n_vec = 0;
    int n_err = 0;

    logic [NC-1:0] mem_m [NR];

    jogo_sequencia_param #(
        .N_CHAVES(NC),
        .DEPTH(16),
        .NUM_RODADAS(NR),
        .SHOW_CYCLES(SHOW),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .chaves(chaves),
        .carrega(carrega),
        .endereco(endereco),
        .dado(dado),
        .acertou(acertou),
        .errou(errou),
        .pronto(pronto),
        .leds(leds),
        .rodada(rodada),
        .timeout(timeout),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick(1);
        chk("start_estado", db_estado, 1);
        chk("start_rodada", rodada, 1);
        chk("start_pronto", pronto, 0);
        iniciar = 1'b0;
    endtask

    task automatic show_round(input int r, input bit chk_leds);
        tick(1);
        chk($sformatf("mostra_estado r%0d", r), db_estado, 2);
        chk($sformatf("mostra_rodada r%0d", r), rodada, r);
        for (int k = 0; k < r * CYC; k++) begin
            if (chk_leds)
                chk($sformatf("leds r%0d k%0d", r, k), leds,
                    ((k % CYC) < SHOW) ? 32'(mem_m[k / CYC]) : 32'd0);
            tick(1);
        end
        chk($sformatf("espera_estado r%0d", r), db_estado, 3);
    endtask

    task automatic play(input logic [NC-1:0] v);
        chaves = v;
        tick(1);
        chk("compara_estado", db_estado, 4);
        chaves = '0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        iniciar  = 1'b0;
        chaves   = '0;
        carrega  = 1'b0;
        endereco = '0;
        dado     = '0;
        mem_m[0] = 4'b0001;
        mem_m[1] = 4'b0010;
        mem_m[2] = 4'b0100;
        mem_m[3] = 4'b1000;

        // 1. reset state, memory load, write blocked during ESPERA
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_acertou", acertou, 0);
        chk("rst_errou", errou, 0);
        chk("rst_pronto", pronto, 0);
        chk("rst_leds", leds, 0);
        chk("rst_rodada", rodada, 0);
        chk("rst_estado", db_estado, 0);
        chk("rst_timeout", timeout, 0);
        for (int i = 0; i < NR; i++) begin
            carrega  = 1'b1;
            endereco = 4'(i);
            dado     = mem_m[i];
            tick(1);
        end
        carrega = 1'b0;
        start_game();
        show_round(1, 1'b1);
        carrega  = 1'b1;
        endereco = 4'd0;
        dado     = 4'b1000;
        tick(1);
        carrega = 1'b0;
        chk("carrega_espera_estado", db_estado, 3);
        play(4'b0001);
        chk("r1_proxima", db_estado, 5);
        chk("r1_rodada", rodada, 1);

        // 2. full win across progressive rounds
        for (int r = 2; r <= NR; r++) begin
            show_round(r, r == 2);
            for (int i = 0; i < r; i++) play(mem_m[i]);
            if (r < NR) chk($sformatf("r%0d_proxima", r), db_estado, 5);
        end
        chk("win_pronto", pronto, 1);
        chk("win_acertou", acertou, 1);
        chk("win_errou", errou, 0);
        chk("win_rodada", rodada, 4);
        chk("win_estado", db_estado, 6);

        // 3. wrong play in round 3, then restart
        start_game();
        show_round(1, 1'b0);
        play(mem_m[0]);
        show_round(2, 1'b0);
        play(mem_m[0]);
        play(mem_m[1]);
        show_round(3, 1'b0);
        play(mem_m[0]);
        chk("r3_espera", db_estado, 3);
        play(4'b0100);
        chk("lose_errou", errou, 1);
        chk("lose_acertou", acertou, 0);
        chk("lose_pronto", pronto, 1);
        chk("lose_rodada", rodada, 3);
        chk("lose_estado", db_estado, 7);
        start_game();
        chk("restart_errou", errou, 0);
        chk("restart_acertou", acertou, 0);

        // 4. non-one-hot play, then a held button counts once
        show_round(1, 1'b0);
        play(4'b0011);
        chk("multi_errou", errou, 1);
        chk("multi_estado", db_estado, 7);
        start_game();
        show_round(1, 1'b0);
        play(mem_m[0]);
        show_round(2, 1'b0);
        chaves = 4'b0001;
        tick(1);
        chk("hold_compara", db_estado, 4);
        tick(1);
        chk("hold_espera", db_estado, 3);
        chk("hold_echo", leds, 4'b0001);
        tick(18);
        chk("hold_still_espera", db_estado, 3);
        chk("hold_rodada", rodada, 2);
        chaves = '0;
        tick(1);
        chk("release_espera", db_estado, 3);
        play(mem_m[1]);
        chk("hold_second_play", db_estado, 5);
        chk("hold_rodada_after", rodada, 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // 5. no play after entering ESPERA
        start_game();
        show_round(1, 1'b0);
`ifdef JOGO_TIMEOUT_EN
        tick(TMO - 1);
        chk("tmo_before", db_estado, 3);
        tick(1);
        chk("tmo_estado", db_estado, 7);
        chk("tmo_timeout", timeout, 1);
        chk("tmo_errou", errou, 1);
`else
        tick(500);
        chk("notmo_estado", db_estado, 3);
        chk("notmo_timeout", timeout, 0);
`endif
        reset = 1'b1;
        tick(1);
        reset = 1'b0;

        // 6. press and reset during playback; load together with start
        start_game();
        show_round(1, 1'b0);
        play(mem_m[0]);
        tick(1);
        chk("m2_estado", db_estado, 2);
        chaves = 4'b0100;
        tick(2);
        chk("m2_press_estado", db_estado, 2);
        chk("m2_press_leds", leds, 32'(mem_m[0]));
        chk("m2_press_rodada", rodada, 2);
        chaves = '0;
        reset  = 1'b1;
        tick(1);
        chk("m2_rst_estado", db_estado, 0);
        chk("m2_rst_leds", leds, 0);
        chk("m2_rst_rodada", rodada, 0);
        reset    = 1'b0;
        carrega  = 1'b1;
        endereco = 4'd0;
        dado     = 4'b0010;
        iniciar  = 1'b1;
        tick(1);
        chk("load_start_estado", db_estado, 1);
        carrega  = 1'b0;
        iniciar  = 1'b0;
        mem_m[0] = 4'b0010;
        show_round(1, 1'b1);
        play(4'b0010);
        chk("load_start_play", db_estado, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
